// File: rtl/bcd_calc_ctrl_if.sv
// Keypad, adder and display signal bundle for the BCD calculator front end.
// master: keypad plus external adder side (drives keys and sum_in; sees operands and display).
// slave:  calculator controller side (sees keys and sum_in; drives operands, display and busy).
interface bcd_calc_ctrl_if;
    logic [9:0]  dkey;      // raw digit-key levels, bit i = digit i
    logic        add_key;   // raw "+" key level
    logic        sub_key;   // raw "-" key level
    logic        eq_key;    // raw "=" key level
    logic        clr_key;   // raw clear key level
    logic [15:0] sum_in;    // BCD result returned by the adder
    logic [15:0] op_a;      // BCD operand A to the adder
    logic [15:0] op_b;      // BCD operand B to the adder
    logic        op_sub;    // 1 = A - B, 0 = A + B
    logic [15:0] disp;      // BCD value to display
    logic [3:0]  disp_en;   // per-digit display enable, bit 0 = least significant digit
    logic        busy;      // high only while the result is being captured

    modport master (
        output dkey, add_key, sub_key, eq_key, clr_key, sum_in,
        input  op_a, op_b, op_sub, disp, disp_en, busy
    );

    modport slave (
        input  dkey, add_key, sub_key, eq_key, clr_key, sum_in,
        output op_a, op_b, op_sub, disp, disp_en, busy
    );
endinterface

// File: rtl/bcd_calc_ctrl.sv
// Keypad-driven 4-digit BCD calculator front end: key edge detect, operand entry, adder handshake.
// Latency: key event acts on the next edge; "=" gives one CALC cycle, result on display two cycles after the edge.
// Backpressure: none; keys are edge events, anything arriving while not meaningful is dropped.
// Ports: hz100/reset plain; bus (slave) carries raw keys, adder result, operands, display value/enables, busy.
module bcd_calc_ctrl #(
    parameter int NDIG = 4
) (
    input  logic            hz100,
    input  logic            reset,
    bcd_calc_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {ENTRY_A, OP_WAIT, ENTRY_B, CALC, RESULT} state_t;

    state_t      state, state_nxt;
    logic [15:0] entry, entry_nxt;
    logic [2:0]  cnt, cnt_nxt;
    logic [15:0] op_a_r, op_a_nxt;
    logic [15:0] op_b_r, op_b_nxt;
    logic        op_sub_r, op_sub_nxt;
    logic [15:0] result, result_nxt;

    logic [9:0]  dkey_q;
    logic        add_q, sub_q, eq_q, clr_q;

    logic [9:0]  dig_ev;
    logic        add_ev, sub_ev, eq_ev, clr_ev;
    logic        op_ev, one_dig;
    logic [3:0]  dig_val;
    logic [15:0] entry_push;
    logic [2:0]  cnt_push;

    assign dig_ev = bus.dkey & ~dkey_q;
    assign add_ev = bus.add_key & ~add_q;
    assign sub_ev = bus.sub_key & ~sub_q;
    assign eq_ev  = bus.eq_key  & ~eq_q;
    assign clr_ev = bus.clr_key & ~clr_q;

    // Simultaneous + and - cancel; a digit counts only if exactly one digit edge is new.
    assign op_ev   = add_ev ^ sub_ev;
    assign one_dig = (dig_ev != 10'd0) && ((dig_ev & (dig_ev - 10'd1)) == 10'd0);

    always_comb begin
        dig_val = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (dig_ev[i]) dig_val = 4'(i);
        end
    end

    // Append a digit while there is room; leading zeros do not consume a digit position.
    always_comb begin
        entry_push = entry;
        cnt_push   = cnt;
        if (cnt < 3'(NDIG) && !(entry == 16'h0000 && dig_val == 4'd0)) begin
            entry_push = {entry[11:0], dig_val};
            cnt_push   = cnt + 3'd1;
        end
    end

    always_comb begin
        state_nxt  = state;
        entry_nxt  = entry;
        cnt_nxt    = cnt;
        op_a_nxt   = op_a_r;
        op_b_nxt   = op_b_r;
        op_sub_nxt = op_sub_r;
        result_nxt = result;

        if (clr_ev) begin
            state_nxt  = ENTRY_A;
            entry_nxt  = 16'h0000;
            cnt_nxt    = 3'd0;
            op_a_nxt   = 16'h0000;
            op_b_nxt   = 16'h0000;
            op_sub_nxt = 1'b0;
            result_nxt = 16'h0000;
        end else begin
            case (state)
                ENTRY_A: begin
                    if (eq_ev) begin
                        state_nxt = ENTRY_A;
                    end else if (op_ev) begin
                        op_a_nxt   = entry;
                        op_sub_nxt = sub_ev;
                        entry_nxt  = 16'h0000;
                        cnt_nxt    = 3'd0;
                        state_nxt  = OP_WAIT;
                    end else if (one_dig) begin
                        entry_nxt = entry_push;
                        cnt_nxt   = cnt_push;
                    end
                end
                OP_WAIT: begin
                    if (eq_ev) begin
                        state_nxt = OP_WAIT;
                    end else if (op_ev) begin
                        op_sub_nxt = sub_ev;
                    end else if (one_dig) begin
                        entry_nxt = {12'h000, dig_val};
                        cnt_nxt   = (dig_val != 4'd0) ? 3'd1 : 3'd0;
                        state_nxt = ENTRY_B;
                    end
                end
                ENTRY_B: begin
                    if (eq_ev) begin
                        op_b_nxt  = entry;
                        state_nxt = CALC;
                    end else if (op_ev) begin
                        state_nxt = ENTRY_B;
                    end else if (one_dig) begin
                        entry_nxt = entry_push;
                        cnt_nxt   = cnt_push;
                    end
                end
                CALC: begin
                    result_nxt = bus.sum_in;
                    state_nxt  = RESULT;
                end
                RESULT: begin
                    if (eq_ev) begin
                        // Repeat the last operation on the previous result.
                        op_a_nxt  = result;
                        state_nxt = CALC;
                    end else if (op_ev) begin
                        op_a_nxt   = result;
                        op_sub_nxt = sub_ev;
                        entry_nxt  = 16'h0000;
                        cnt_nxt    = 3'd0;
                        state_nxt  = OP_WAIT;
                    end else if (one_dig) begin
                        entry_nxt = {12'h000, dig_val};
                        cnt_nxt   = (dig_val != 4'd0) ? 3'd1 : 3'd0;
                        state_nxt = ENTRY_A;
                    end
                end
                default: state_nxt = ENTRY_A;
            endcase
        end
    end

    always_ff @(posedge hz100) begin
        if (reset) begin
            state    <= ENTRY_A;
            entry    <= 16'h0000;
            cnt      <= 3'd0;
            op_a_r   <= 16'h0000;
            op_b_r   <= 16'h0000;
            op_sub_r <= 1'b0;
            result   <= 16'h0000;
            dkey_q   <= 10'd0;
            add_q    <= 1'b0;
            sub_q    <= 1'b0;
            eq_q     <= 1'b0;
            clr_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            entry    <= entry_nxt;
            cnt      <= cnt_nxt;
            op_a_r   <= op_a_nxt;
            op_b_r   <= op_b_nxt;
            op_sub_r <= op_sub_nxt;
            result   <= result_nxt;
            // Key history keeps tracking through clr so a held clr is one event.
            dkey_q   <= bus.dkey;
            add_q    <= bus.add_key;
            sub_q    <= bus.sub_key;
            eq_q     <= bus.eq_key;
            clr_q    <= bus.clr_key;
        end
    end

    function automatic logic [3:0] cnt_mask(input logic [2:0] c);
        case (c)
            3'd0, 3'd1: cnt_mask = 4'b0001;
            3'd2:       cnt_mask = 4'b0011;
            3'd3:       cnt_mask = 4'b0111;
            default:    cnt_mask = 4'b1111;
        endcase
    endfunction

    // Enables covering the significant digits of a value; at least the units digit.
    function automatic logic [3:0] sig_mask(input logic [15:0] v);
        if (v[15:12] != 4'd0)     sig_mask = 4'b1111;
        else if (v[11:8] != 4'd0) sig_mask = 4'b0111;
        else if (v[7:4] != 4'd0)  sig_mask = 4'b0011;
        else                      sig_mask = 4'b0001;
    endfunction

    always_comb begin
        bus.disp    = entry;
        bus.disp_en = cnt_mask(cnt);
        case (state)
            OP_WAIT: begin
                bus.disp    = op_a_r;
                bus.disp_en = sig_mask(op_a_r);
            end
            CALC: begin
                bus.disp    = op_b_r;
                bus.disp_en = sig_mask(op_b_r);
            end
            RESULT: begin
                bus.disp    = result;
                bus.disp_en = 4'b1111;
            end
            default: begin
                bus.disp    = entry;
                bus.disp_en = cnt_mask(cnt);
            end
        endcase
    end

    assign bus.op_a   = op_a_r;
    assign bus.op_b   = op_b_r;
    assign bus.op_sub = op_sub_r;
    assign bus.busy   = (state == CALC);

endmodule

// File: tb/tb_bcd_calc_ctrl.sv
module tb_bcd_calc_ctrl;

    localparam int M_A = 0;
    localparam int M_W = 1;
    localparam int M_B = 2;
    localparam int M_R = 3;

    logic hz100 = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    // Calculator reference state, held as plain integers.
    int m_mode, m_entry, m_cnt, m_a, m_b, m_sub, m_res;

    bcd_calc_ctrl_if bus ();

    bcd_calc_ctrl #(.NDIG(4)) dut (
        .hz100 (hz100),
        .reset (reset),
        .bus   (bus)
    );

    always #5 hz100 = ~hz100;

    function automatic int bcd2int(input logic [15:0] v);
        return int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] r;
        int t;
        t = v;
        r = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int arith(input int a, input int b, input int sub);
        if (sub != 0) return (a - b + 10000) % 10000;
        return (a + b) % 10000;
    endfunction

    // External adder: combinational BCD add/subtract modulo 10000.
    assign bus.sum_in = int2bcd(arith(bcd2int(bus.op_a), bcd2int(bus.op_b), int'(bus.op_sub)));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge hz100);
        @(negedge hz100);
    endtask

    task automatic model_reset();
        m_mode = M_A; m_entry = 0; m_cnt = 0; m_a = 0; m_b = 0; m_sub = 0; m_res = 0;
    endtask

    function automatic logic [3:0] exp_en();
        int n;
        if (m_mode == M_R) return 4'b1111;
        if (m_mode == M_W) n = (m_a >= 1000) ? 4 : (m_a >= 100) ? 3 : (m_a >= 10) ? 2 : 1;
        else               n = (m_cnt < 1) ? 1 : m_cnt;
        return 4'((1 << n) - 1);
    endfunction

    task automatic check_all(input string ctx);
        int dv;
        dv = (m_mode == M_W) ? m_a : (m_mode == M_R) ? m_res : m_entry;
        chk({ctx, ".op_a"},    32'(bus.op_a),    32'(int2bcd(m_a)));
        chk({ctx, ".op_b"},    32'(bus.op_b),    32'(int2bcd(m_b)));
        chk({ctx, ".op_sub"},  32'(bus.op_sub),  32'(m_sub));
        chk({ctx, ".disp"},    32'(bus.disp),    32'(int2bcd(dv)));
        chk({ctx, ".disp_en"}, 32'(bus.disp_en), 32'(exp_en()));
        chk({ctx, ".busy"},    32'(bus.busy),    32'd0);
    endtask

    // Apply one set of new key presses to the reference; returns whether a calculation starts.
    task automatic model_keys(input logic [9:0] dk, input logic a, input logic s,
                              input logic e, input logic c, output bit calc);
        int d;
        calc = 1'b0;
        d = 0;
        for (int i = 0; i < 10; i++) if (dk[i]) d = i;
        if (c) begin
            model_reset();
        end else if (e) begin
            if (m_mode == M_B) begin
                m_b = m_entry; calc = 1'b1;
            end else if (m_mode == M_R) begin
                m_a = m_res; calc = 1'b1;
            end
        end else if (a ^ s) begin
            if (m_mode == M_A) begin
                m_a = m_entry; m_sub = int'(s); m_entry = 0; m_cnt = 0; m_mode = M_W;
            end else if (m_mode == M_W) begin
                m_sub = int'(s);
            end else if (m_mode == M_R) begin
                m_a = m_res; m_sub = int'(s); m_entry = 0; m_cnt = 0; m_mode = M_W;
            end
        end else if ($countones(dk) == 1) begin
            if (m_mode == M_A || m_mode == M_B) begin
                if (m_cnt < 4 && !(m_entry == 0 && d == 0)) begin
                    m_entry = m_entry * 10 + d;
                    m_cnt++;
                end
            end else begin
                m_entry = d;
                m_cnt = (d != 0) ? 1 : 0;
                m_mode = (m_mode == M_W) ? M_B : M_A;
            end
        end
    endtask

    task automatic release_keys();
        bus.dkey = 10'd0; bus.add_key = 1'b0; bus.sub_key = 1'b0;
        bus.eq_key = 1'b0; bus.clr_key = 1'b0;
    endtask

    task automatic press(input logic [9:0] dk, input logic a, input logic s,
                         input logic e, input logic c, input int hold);
        bit calc;
        bus.dkey = dk; bus.add_key = a; bus.sub_key = s; bus.eq_key = e; bus.clr_key = c;
        model_keys(dk, a, s, e, c, calc);
        tick();
        if (calc) begin
            chk("busy_calc", 32'(bus.busy), 32'd1);
            m_res = arith(m_a, m_b, m_sub);
            m_mode = M_R;
        end
        for (int i = 1; i < hold; i++) tick();
        release_keys();
        tick();
        check_all("press");
    endtask

    task automatic key_d(input int d);
        press(10'(1 << d), 1'b0, 1'b0, 1'b0, 1'b0, 1);
    endtask
    task automatic key_add(); press(10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1); endtask
    task automatic key_sub(); press(10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1); endtask
    task automatic key_eq();  press(10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1); endtask
    task automatic key_clr(); press(10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1); endtask

    initial begin
        int r, d1, d2;
        release_keys();
        reset = 1'b1;
        model_reset();
        tick();
        tick();
        check_all("reset");
        chk("reset.disp_en_const", 32'(bus.disp_en), 32'h1);
        reset = 1'b0;
        tick();
        check_all("post_reset");

        // Five digits: only the first four are taken.
        key_d(1); key_d(2); key_d(3); key_d(4); key_d(5);
        chk("d1234.disp", 32'(bus.disp), 32'h1234);
        chk("d1234.en", 32'(bus.disp_en), 32'hf);
        key_clr();

        // 9876 + 3333 = 3209, carry out dropped.
        key_d(9); key_d(8); key_d(7); key_d(6); key_add();
        key_d(3); key_d(3); key_d(3); key_d(3); key_eq();
        chk("sum3209", 32'(bus.disp), 32'h3209);
        key_clr();

        // Underflow wraps, then repeat.
        key_d(0); key_sub(); key_d(1); key_eq();
        chk("wrap9999", 32'(bus.disp), 32'h9999);
        key_eq();
        chk("repeat9998", 32'(bus.disp), 32'h9998);
        key_clr();

        // Operator overwrite in OP_WAIT.
        key_d(2); key_d(5); key_add(); key_sub(); key_d(7);
        chk("opsub", 32'(bus.op_sub), 32'h1);
        key_eq();
        chk("diff0018", 32'(bus.disp), 32'h0018);
        key_clr();

        // Holding a digit key enters one digit.
        press(10'(1 << 7), 1'b0, 1'b0, 1'b0, 1'b0, 50);
        chk("hold.disp", 32'(bus.disp), 32'h0007);
        key_clr();

        // clr together with eq wins.
        key_d(1); key_d(2); key_add(); key_d(3);
        press(10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1);
        chk("clr_eq.disp", 32'(bus.disp), 32'h0);
        chk("clr_eq.op_a", 32'(bus.op_a), 32'h0);

        // Two digit keys at once enter nothing.
        press(10'(1 << 4) | 10'(1 << 6), 1'b0, 1'b0, 1'b0, 1'b0, 1);
        chk("multi.disp", 32'(bus.disp), 32'h0);
        chk("multi.en", 32'(bus.disp_en), 32'h1);

        // clr arriving during the CALC cycle aborts the capture.
        key_d(5); key_add(); key_d(5);
        bus.eq_key = 1'b1;
        tick();
        chk("abort.busy", 32'(bus.busy), 32'd1);
        bus.eq_key = 1'b0;
        bus.clr_key = 1'b1;
        tick();
        model_reset();
        release_keys();
        tick();
        check_all("abort");

        // Randomized key sequences.
        for (int it = 0; it < 250; it++) begin
            r = $urandom_range(0, 99);
            if (r < 55) begin
                key_d($urandom_range(0, 9));
            end else if (r < 67) begin
                key_add();
            end else if (r < 77) begin
                key_sub();
            end else if (r < 90) begin
                key_eq();
            end else if (r < 93) begin
                key_clr();
            end else if (r < 96) begin
                d1 = $urandom_range(0, 9);
                d2 = (d1 + 1 + $urandom_range(0, 8)) % 10;
                press(10'(1 << d1) | 10'(1 << d2), 1'b0, 1'b0, 1'b0, 1'b0, 1);
            end else begin
                press(10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
